// File: rtl/slb_pkg.sv
// Shared types, widths and helpers for the store/load buffer.
// Op codes, tag/data/address widths and the entry count live here.
package slb_pkg;

  localparam int SlbNum = 16;
  localparam int DEPTH  = SlbNum;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int NICK_W = 5;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [NICK_W-1:0] nick_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [PTR_W:0]    cnt_t;

  typedef enum logic [2:0] {
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } op_e;

  typedef enum logic {S_IDLE, S_MEM} state_e;

  // Operand value plus producer tag; tag 0 means the value is ready.
  typedef struct packed {
    data_t v;
    nick_t q;
  } opnd_t;

  typedef struct packed {
    logic  valid;
    logic  commit;
    op_e   op;
    nick_t nick;
    opnd_t j;
    opnd_t k;
    data_t imm;
  } entry_t;

  function automatic logic is_store(op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [1:0] mem_len(op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: mem_len = 2'b00;
      OP_LH, OP_LHU, OP_SH: mem_len = 2'b01;
      default:              mem_len = 2'b11;
    endcase
  endfunction

  // CDB takes priority over our own load result if both carry the tag.
  function automatic opnd_t wake(opnd_t o, logic ex_en, nick_t ex_nick, data_t ex_dt,
                                 logic rb_en, nick_t rb_nick, data_t rb_dt);
    wake = o;
    if (o.q != '0) begin
      if (ex_en && o.q == ex_nick) begin
        wake.v = ex_dt;
        wake.q = '0;
      end else if (rb_en && o.q == rb_nick) begin
        wake.v = rb_dt;
        wake.q = '0;
      end
    end
  endfunction

endpackage

// File: rtl/slb_if.sv
// Bus bundle for the store/load buffer: dispatch, CDB, rob commit,
// memory controller and load-result signals. slave = the buffer itself.
interface slb_if;
  import slb_pkg::*;

  logic  rdy;
  logic  clr;
  logic  oINF_full;
  logic  iDP_en;
  op_e   iDP_op;
  nick_t iDP_nick;
  data_t iDP_vj;
  nick_t iDP_qj;
  data_t iDP_vk;
  nick_t iDP_qk;
  data_t iDP_imm;
  logic  iEX_en;
  nick_t iEX_nick;
  data_t iEX_dt;
  logic  iROB_store_en;
  nick_t iROB_store_nick;
  logic  oMC_en;
  logic  oMC_wr;
  addr_t oMC_addr;
  data_t oMC_dt;
  logic [1:0] oMC_len;
  logic  iMC_done;
  data_t iMC_dt;
  logic  oROB_en;
  nick_t oROB_nick;
  data_t oROB_dt;

  modport slave (
    input  rdy, clr, iDP_en, iDP_op, iDP_nick, iDP_vj, iDP_qj, iDP_vk, iDP_qk, iDP_imm,
    input  iEX_en, iEX_nick, iEX_dt, iROB_store_en, iROB_store_nick, iMC_done, iMC_dt,
    output oINF_full, oMC_en, oMC_wr, oMC_addr, oMC_dt, oMC_len, oROB_en, oROB_nick, oROB_dt
  );

  modport master (
    output rdy, clr, iDP_en, iDP_op, iDP_nick, iDP_vj, iDP_qj, iDP_vk, iDP_qk, iDP_imm,
    output iEX_en, iEX_nick, iEX_dt, iROB_store_en, iROB_store_nick, iMC_done, iMC_dt,
    input  oINF_full, oMC_en, oMC_wr, oMC_addr, oMC_dt, oMC_len, oROB_en, oROB_nick, oROB_dt
  );

endinterface

// File: rtl/slb_ext.sv
// Combinational load-data extension: sign/zero-extends raw low-aligned
// memory data according to the load op.
module slb_ext
  import slb_pkg::*;
(
  input  op_e   op_i,
  input  data_t raw_i,
  output data_t dt_o
);

  always_comb begin
    dt_o = raw_i;
    case (op_i)
      OP_LB:   dt_o = {{24{raw_i[7]}}, raw_i[7:0]};
      OP_LH:   dt_o = {{16{raw_i[15]}}, raw_i[15:0]};
      OP_LBU:  dt_o = {24'h0, raw_i[7:0]};
      OP_LHU:  dt_o = {16'h0, raw_i[15:0]};
      default: dt_o = raw_i;
    endcase
  end

endmodule

// File: rtl/slb.sv
// In-order store/load buffer with operand wakeup, store commit and flush.
// Define SLB_PERF_EN to add the oPerf_stall head-stall cycle counter.
module slb
  import slb_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef SLB_PERF_EN
  output logic [31:0] oPerf_stall,
`endif
  slb_if.slave bus
);

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  ptr_t   head_q, head_d, tail_q, tail_d, head_n;
  cnt_t   count_q, count_d, keep, keep_after;
  state_e state_q, state_d;
  logic   kill_q, kill_d;
  logic   mc_en_q, mc_en_d, mc_wr_q, mc_wr_d;
  addr_t  mc_addr_q, mc_addr_d;
  data_t  mc_dt_q, mc_dt_d;
  logic [1:0] mc_len_q, mc_len_d;
  logic   rob_en_q, rob_en_d;
  nick_t  rob_nick_q, rob_nick_d;
  data_t  rob_dt_q, rob_dt_d;
  logic [DEPTH-1:0] cm;
  entry_t hd;
  logic   hd_store, hd_ready, pop, dp;
  data_t  ext_dt;
  opnd_t  dj, dk;

  assign hd       = ent_q[head_q];
  assign hd_store = is_store(hd.op);
  assign hd_ready = hd.valid && hd.j.q == '0 && (!hd_store || (hd.k.q == '0 && hd.commit));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_commit
    assign cm[gi] = bus.iROB_store_en && ent_q[gi].valid && ent_q[gi].nick == bus.iROB_store_nick;
  end

  slb_ext u_ext (.op_i(hd.op), .raw_i(bus.iMC_dt), .dt_o(ext_dt));

  // A load issued before a flush is marked killed: it must still drain
  // the memory handshake, but neither pops nor broadcasts.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    mc_en_d    = mc_en_q;
    mc_wr_d    = mc_wr_q;
    mc_addr_d  = mc_addr_q;
    mc_dt_d    = mc_dt_q;
    mc_len_d   = mc_len_q;
    rob_en_d   = 1'b0;
    rob_nick_d = rob_nick_q;
    rob_dt_d   = rob_dt_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hd_ready && !(bus.clr && !hd_store)) begin
          state_d   = S_MEM;
          kill_d    = 1'b0;
          mc_en_d   = 1'b1;
          mc_wr_d   = hd_store;
          mc_addr_d = hd.j.v + hd.imm;
          mc_dt_d   = hd.k.v;
          mc_len_d  = mem_len(hd.op);
        end
      end
      S_MEM: begin
        if (bus.iMC_done) begin
          state_d = S_IDLE;
          mc_en_d = 1'b0;
          mc_wr_d = 1'b0;
          kill_d  = 1'b0;
          pop     = !kill_q;
          if (!kill_q && !mc_wr_q && !bus.clr) begin
            rob_en_d   = 1'b1;
            rob_nick_d = hd.nick;
            rob_dt_d   = ext_dt;
          end
        end else if (bus.clr && !mc_wr_q) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ent_d      = ent_q;
    keep       = '0;
    keep_after = '0;
    dp         = bus.iDP_en && !bus.clr;
    head_n     = head_q + ptr_t'(pop);
    dj         = wake('{v: bus.iDP_vj, q: bus.iDP_qj}, bus.iEX_en, bus.iEX_nick, bus.iEX_dt,
                      rob_en_q, rob_nick_q, rob_dt_q);
    dk         = wake('{v: bus.iDP_vk, q: bus.iDP_qk}, bus.iEX_en, bus.iEX_nick, bus.iEX_dt,
                      rob_en_q, rob_nick_q, rob_dt_q);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i].j = wake(ent_q[i].j, bus.iEX_en, bus.iEX_nick, bus.iEX_dt, rob_en_q, rob_nick_q, rob_dt_q);
      ent_d[i].k = wake(ent_q[i].k, bus.iEX_en, bus.iEX_nick, bus.iEX_dt, rob_en_q, rob_nick_q, rob_dt_q);
      if (cm[i]) ent_d[i].commit = 1'b1;
    end
    if (pop) ent_d[head_q].valid = 1'b0;
    if (dp) begin
      ent_d[tail_q].valid  = 1'b1;
      ent_d[tail_q].commit = 1'b0;
      ent_d[tail_q].op     = bus.iDP_op;
      ent_d[tail_q].nick   = bus.iDP_nick;
      ent_d[tail_q].j      = dj;
      ent_d[tail_q].k      = dk;
      ent_d[tail_q].imm    = bus.iDP_imm;
    end
    head_d  = head_n;
    tail_d  = tail_q + ptr_t'(dp);
    count_d = count_q + cnt_t'(dp) - cnt_t'(pop);
    // Committed stores always form a prefix from head, so the survivors
    // are simply the first keep_after entries past the new head.
    if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && (ent_q[i].commit || cm[i])) keep = keep + 1'b1;
        else ent_d[i].valid = 1'b0;
      end
      keep_after = keep - cnt_t'(pop && (hd.commit || cm[head_q]));
      tail_d     = head_n + ptr_t'(keep_after);
      count_d    = keep_after;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else if (bus.rdy) state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      kill_q     <= 1'b0;
      mc_en_q    <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_dt_q    <= '0;
      mc_len_q   <= '0;
      rob_en_q   <= 1'b0;
      rob_nick_q <= '0;
      rob_dt_q   <= '0;
    end else if (bus.rdy) begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      kill_q     <= kill_d;
      mc_en_q    <= mc_en_d;
      mc_wr_q    <= mc_wr_d;
      mc_addr_q  <= mc_addr_d;
      mc_dt_q    <= mc_dt_d;
      mc_len_q   <= mc_len_d;
      rob_en_q   <= rob_en_d;
      rob_nick_q <= rob_nick_d;
      rob_dt_q   <= rob_dt_d;
    end
  end

`ifdef SLB_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else if (bus.rdy && state_q == S_IDLE && hd.valid && !hd_ready && perf_q != 32'hFFFF_FFFF)
      perf_q <= perf_q + 32'd1;
  end
  assign oPerf_stall = perf_q;
`endif

  assign bus.oINF_full = (count_q >= cnt_t'(DEPTH - 1));
  assign bus.oMC_en    = mc_en_q;
  assign bus.oMC_wr    = mc_wr_q;
  assign bus.oMC_addr  = mc_addr_q;
  assign bus.oMC_dt    = mc_dt_q;
  assign bus.oMC_len   = mc_len_q;
  assign bus.oROB_en   = rob_en_q;
  assign bus.oROB_nick = rob_nick_q;
  assign bus.oROB_dt   = rob_dt_q;

endmodule

// File: tb/tb_slb.sv
// Scoreboard bench for slb: stimulus pushes expected memory requests and
// load results; a monitor pops and compares them as the DUT presents them.
module tb_slb;
  import slb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  slb_if bus ();
`ifdef SLB_PERF_EN
  logic [31:0] perf;
`endif

  slb dut (
    .clk(clk),
    .rst(rst),
`ifdef SLB_PERF_EN
    .oPerf_stall(perf),
`endif
    .bus(bus)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [1:0] len; logic [31:0] dt; } mc_t;
  typedef struct { logic [4:0] nick; logic [31:0] dt; } rb_t;

  mc_t         exp_mc[$];
  rb_t         exp_rob[$];
  logic [31:0] mem_rd_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mem_hold = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  // Monitor / scoreboard
  initial begin
    mc_t  em;
    rb_t  er;
    logic mc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.oMC_en && !mc_prev) begin
          $display("mc  wr=%0b addr=%h len=%b dt=%h", bus.oMC_wr, bus.oMC_addr, bus.oMC_len, bus.oMC_dt);
          if (exp_mc.size() == 0) chk("mc_unexpected", 32'd1, 32'd0);
          else begin
            em = exp_mc.pop_front();
            chk("mc_wr", {31'd0, bus.oMC_wr}, {31'd0, em.wr});
            chk("mc_addr", bus.oMC_addr, em.addr);
            chk("mc_len", {30'd0, bus.oMC_len}, {30'd0, em.len});
            if (em.wr) chk("mc_dt", bus.oMC_dt, em.dt);
          end
        end
        if (bus.oROB_en) begin
          $display("rob nick=%0d dt=%h", bus.oROB_nick, bus.oROB_dt);
          if (exp_rob.size() == 0) chk("rob_unexpected", 32'd1, 32'd0);
          else begin
            er = exp_rob.pop_front();
            chk("rob_nick", {27'd0, bus.oROB_nick}, {27'd0, er.nick});
            chk("rob_dt", bus.oROB_dt, er.dt);
          end
        end
      end
      mc_prev = bus.oMC_en;
    end
  end

  // Memory controller model: one-cycle done pulse after each request
  initial begin
    logic [31:0] rd;
    bus.iMC_done = 1'b0;
    bus.iMC_dt   = '0;
    forever begin
      @(negedge clk);
      if (bus.oMC_en && !rst) begin
        while (mem_hold) @(negedge clk);
        rd = (!bus.oMC_wr && mem_rd_q.size() > 0) ? mem_rd_q.pop_front() : 32'h0;
        @(posedge clk); #1;
        bus.iMC_done = 1'b1;
        bus.iMC_dt   = rd;
        @(posedge clk); #1;
        bus.iMC_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic dispatch(op_e op, logic [4:0] nick, logic [31:0] vj, logic [4:0] qj,
                          logic [31:0] vk, logic [4:0] qk, logic [31:0] imm);
    bus.iDP_en   = 1'b1;
    bus.iDP_op   = op;
    bus.iDP_nick = nick;
    bus.iDP_vj   = vj;
    bus.iDP_qj   = qj;
    bus.iDP_vk   = vk;
    bus.iDP_qk   = qk;
    bus.iDP_imm  = imm;
    tick();
    bus.iDP_en   = 1'b0;
  endtask

  task automatic exp_load(logic [31:0] addr, logic [1:0] len, logic [31:0] raw,
                          logic [4:0] nick, logic [31:0] dt);
    exp_mc.push_back('{wr: 1'b0, addr: addr, len: len, dt: 32'h0});
    mem_rd_q.push_back(raw);
    exp_rob.push_back('{nick: nick, dt: dt});
  endtask

  task automatic commit(logic [4:0] nick);
    bus.iROB_store_en   = 1'b1;
    bus.iROB_store_nick = nick;
    tick();
    bus.iROB_store_en   = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    while ((exp_mc.size() != 0 || exp_rob.size() != 0 || bus.oMC_en) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, k >= 400}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic watch_no_mc(string name, int cycles);
    logic saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      saw |= bus.oMC_en;
    end
    chk(name, {31'd0, saw}, 32'd0);
    tick();
  endtask

  op_e         t_op  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
  logic [31:0] t_raw [4] = '{32'h0000_00F0, 32'h0000_00F0, 32'h0000_8001, 32'h0000_8001};
  logic [31:0] t_exp [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'h0000_8001};
  logic [1:0]  t_len [4] = '{2'b00, 2'b00, 2'b01, 2'b01};

  initial begin
    bus.rdy = 1'b1; bus.clr = 1'b0;
    bus.iDP_en = 1'b0; bus.iDP_op = OP_LW; bus.iDP_nick = '0;
    bus.iDP_vj = '0; bus.iDP_qj = '0; bus.iDP_vk = '0; bus.iDP_qk = '0; bus.iDP_imm = '0;
    bus.iEX_en = 1'b0; bus.iEX_nick = '0; bus.iEX_dt = '0;
    bus.iROB_store_en = 1'b0; bus.iROB_store_nick = '0;

    #1 rst = 1'b1;
    #2;
    chk("rst_full", {31'd0, bus.oINF_full}, 32'd0);
    chk("rst_mc_en", {31'd0, bus.oMC_en}, 32'd0);
    chk("rst_rob_en", {31'd0, bus.oROB_en}, 32'd0);
    chk("rst_rob_dt", bus.oROB_dt, 32'd0);
    #20 rst = 1'b0;
    tick(); tick();

    // Word load, address = base + offset
    exp_load(32'h104, 2'b11, 32'h80, 5'd3, 32'h80);
    dispatch(OP_LW, 5'd3, 32'h100, 5'd0, 32'h0, 5'd0, 32'd4);
    wait_idle("lw_timeout");

    // Sub-word loads with sign/zero extension; negative offset wraps
    for (int i = 0; i < 4; i++) begin
      exp_load(32'h1FF, t_len[i], t_raw[i], 5'(4 + i), t_exp[i]);
      dispatch(t_op[i], 5'(4 + i), 32'h200, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF);
      wait_idle("ext_timeout");
    end

    // Store waits on data tag and commit; an unrelated commit is ignored
    dispatch(OP_SW, 5'd5, 32'h40, 5'd0, 32'h0, 5'd2, 32'd8);
    bus.iEX_en = 1'b1; bus.iEX_nick = 5'd2; bus.iEX_dt = 32'hDEAD;
    tick();
    bus.iEX_en = 1'b0;
    commit(5'd22);
    watch_no_mc("sw_wait_commit", 6);
    exp_mc.push_back('{wr: 1'b1, addr: 32'h48, len: 2'b11, dt: 32'hDEAD});
    commit(5'd5);
    wait_idle("sw_timeout");

    // Load woken by our own load result, then a same-cycle CDB dispatch
    exp_load(32'h300, 2'b11, 32'h500, 5'd9, 32'h500);
    exp_load(32'h504, 2'b11, 32'h77, 5'd10, 32'h77);
    dispatch(OP_LW, 5'd9, 32'h300, 5'd0, 32'h0, 5'd0, 32'd0);
    dispatch(OP_LW, 5'd10, 32'h0, 5'd9, 32'h0, 5'd0, 32'd4);
    wait_idle("dep_timeout");
    exp_load(32'h608, 2'b01, 32'h1234, 5'd11, 32'h1234);
    bus.iEX_en = 1'b1; bus.iEX_nick = 5'd12; bus.iEX_dt = 32'h600;
    dispatch(OP_LHU, 5'd11, 32'h0, 5'd12, 32'h0, 5'd0, 32'd8);
    bus.iEX_en = 1'b0;
    wait_idle("same_cycle_timeout");

    // Fill to DEPTH-1 with blocked loads; full drops after the first pop
    for (int i = 0; i < 15; i++) begin
      exp_load(32'h1000 + 32'(i * 4), 2'b11, 32'h100 + 32'(i), 5'(i + 1), 32'h100 + 32'(i));
      dispatch(OP_LW, 5'(i + 1), 32'h0, 5'd20, 32'h0, 5'd0, 32'(i * 4));
      if (i == 13) chk("full_at_14", {31'd0, bus.oINF_full}, 32'd0);
      if (i == 14) chk("full_at_15", {31'd0, bus.oINF_full}, 32'd1);
    end
    bus.iEX_en = 1'b1; bus.iEX_nick = 5'd20; bus.iEX_dt = 32'h1000;
    tick();
    bus.iEX_en = 1'b0;
    begin
      int k = 0;
      while (!bus.oROB_en && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("first_pop_timeout", {31'd0, k >= 50}, 32'd0);
      chk("full_after_pop", {31'd0, bus.oINF_full}, 32'd0);
    end
    wait_idle("fill_timeout");

    // Flush with a committed store in flight and two loads behind it
    mem_hold = 1'b1;
    exp_mc.push_back('{wr: 1'b1, addr: 32'h80, len: 2'b11, dt: 32'h55});
    dispatch(OP_SW, 5'd13, 32'h80, 5'd0, 32'h55, 5'd0, 32'd0);
    commit(5'd13);
    dispatch(OP_LW, 5'd14, 32'h90, 5'd0, 32'h0, 5'd0, 32'd0);
    dispatch(OP_LW, 5'd15, 32'h94, 5'd0, 32'h0, 5'd0, 32'd0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_store_count", 32'(dut.count_q), 32'd1);
    mem_hold = 1'b0;
    wait_idle("clr_store_timeout");
    chk("clr_store_empty", 32'(dut.count_q), 32'd0);

    // Flush during an in-flight load: drains, no result, then recovers
    mem_hold = 1'b1;
    exp_mc.push_back('{wr: 1'b0, addr: 32'h700, len: 2'b11, dt: 32'h0});
    dispatch(OP_LW, 5'd16, 32'h700, 5'd0, 32'h0, 5'd0, 32'd0);
    repeat (3) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_load_count", 32'(dut.count_q), 32'd0);
    mem_hold = 1'b0;
    wait_idle("clr_load_timeout");
    repeat (4) tick();
    exp_load(32'h710, 2'b11, 32'hCAFE, 5'd17, 32'hCAFE);
    dispatch(OP_LW, 5'd17, 32'h710, 5'd0, 32'h0, 5'd0, 32'd0);
    wait_idle("recover_timeout");

    chk("exp_mc_drained", 32'(exp_mc.size()), 32'd0);
    chk("exp_rob_drained", 32'(exp_rob.size()), 32'd0);

    // Asynchronous reset mid-cycle while a request is outstanding
    mem_hold = 1'b1;
    exp_mc.push_back('{wr: 1'b0, addr: 32'h900, len: 2'b11, dt: 32'h0});
    dispatch(OP_LW, 5'd18, 32'h900, 5'd0, 32'h0, 5'd0, 32'd0);
    begin
      int k = 0;
      while (!bus.oMC_en && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("async_issue_timeout", {31'd0, k >= 20}, 32'd0);
    end
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_mc_en", {31'd0, bus.oMC_en}, 32'd0);
    chk("async_mc_addr", bus.oMC_addr, 32'd0);
    chk("async_count", 32'(dut.count_q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
